// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI slave receiver.
package spi_pkg;

  localparam int unsigned SPI_DATA_W = 8;

  typedef enum logic {
    IDLE,
    SHIFT
  } spi_state_e;

endpackage

// File: rtl/spi_slave_if.sv
// Receive-side valid/ready holding-register bus of spi_slave.
interface spi_slave_if
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = SPI_DATA_W
);

  logic [DATA_W-1:0] rx_data;
  logic              rx_dc;
  logic              rx_valid;
  logic              rx_ready;

  modport slave  (output rx_data, rx_dc, rx_valid, input  rx_ready);
  modport master (input  rx_data, rx_dc, rx_valid, output rx_ready);

endinterface

// File: rtl/spi_sync.sv
// Multi-stage input synchronizer with registered rise/fall strobes.
module spi_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= {STAGES{RST_VAL}};
      prev <= RST_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      prev <= sync[STAGES-1];
      rise <= sync[STAGES-1] & ~prev;
      fall <= ~sync[STAGES-1] & prev;
    end
  end

  assign q = sync[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-3 slave receiver with one-entry valid/ready holding register.
// Define SPI_SLAVE_MISO_EN to add the tx buffer and drive miso.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W      = SPI_DATA_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              cs,
  input  logic              mosi,
  input  logic              dc,
  output logic              miso,
  spi_slave_if.slave        rx,
  output logic              rx_overrun,
  output logic              frame_err,
`ifdef SPI_SLAVE_MISO_EN
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
`endif
  input  logic              clr_err
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  logic sck_s, sck_rise, sck_fall;
  logic cs_s,  cs_rise,  cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic dc_s,   dc_rise,   dc_fall;

  // sck and cs reset to their idle-high levels so release gives no false edge
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sck (
    .clk(clk), .rst(rst), .d(sck), .q(sck_s), .rise(sck_rise), .fall(sck_fall));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .d(cs), .q(cs_s), .rise(cs_rise), .fall(cs_fall));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(mosi), .q(mosi_s), .rise(mosi_rise), .fall(mosi_fall));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_dc (
    .clk(clk), .rst(rst), .d(dc), .q(dc_s), .rise(dc_rise), .fall(dc_fall));

  logic unused_edges;
  assign unused_edges = ^{sck_s, cs_s, sck_fall, mosi_rise, mosi_fall, dc_rise, dc_fall};

  spi_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_dc_q;
  logic              rx_valid_q;
  logic              last_bit;

  assign last_bit = (cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      rx_data_q  <= '0;
      rx_dc_q    <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (rx_valid_q && rx.rx_ready) rx_valid_q <= 1'b0;
      if (clr_err) rx_overrun <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state <= SHIFT;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state     <= IDLE;
            cnt       <= '0;
            frame_err <= (cnt != '0);
          end else if (sck_rise) begin
            shreg <= {shreg[DATA_W-2:0], mosi_s};
            if (last_bit) begin
              cnt <= '0;
              if (!rx_valid_q || rx.rx_ready) begin
                rx_data_q  <= {shreg[DATA_W-2:0], mosi_s};
                rx_dc_q    <= dc_s;
                rx_valid_q <= 1'b1;
              end else begin
                rx_overrun <= 1'b1;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rx.rx_data  = rx_data_q;
  assign rx.rx_dc    = rx_dc_q;
  assign rx.rx_valid = rx_valid_q;

`ifdef SPI_SLAVE_MISO_EN
  logic [DATA_W-1:0] tx_buf;
  logic [DATA_W-1:0] tx_sh;
  logic              tx_full;
  logic              word_start;

  always_comb begin
    word_start = 1'b0;
    if (state == IDLE && cs_fall) word_start = 1'b1;
    if (state == SHIFT && !cs_rise && sck_rise && last_bit) word_start = 1'b1;
  end

  // A word's first falling edge (cnt==0) precedes its MSB sample, so it must not shift
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_buf  <= '0;
      tx_sh   <= '0;
      tx_full <= 1'b0;
    end else begin
      if (word_start) begin
        tx_sh   <= tx_full ? tx_buf : '0;
        tx_full <= 1'b0;
      end else if (state == SHIFT && sck_fall && cnt != '0) begin
        tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
      end
      if (tx_load && !tx_full) begin
        tx_buf  <= tx_data;
        tx_full <= 1'b1;
      end
    end
  end

  assign tx_ready = ~tx_full;
  assign miso     = (state == SHIFT) & tx_sh[DATA_W-1];
`else
  assign miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: mode-3 master model, valid/ready consumer.
module tb_spi_slave;
  import spi_pkg::*;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SYNC   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sck = 1'b1;
  logic cs = 1'b1;
  logic mosi = 1'b0;
  logic dc = 1'b0;
  logic clr_err = 1'b0;
  logic miso, rx_overrun, frame_err;

  spi_slave_if #(.DATA_W(DATA_W)) rx_if ();

`ifdef SPI_SLAVE_MISO_EN
  logic [DATA_W-1:0] tx_data = '0;
  logic              tx_load = 1'b0;
  logic              tx_ready;
`endif

  spi_slave #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC)) dut (
    .clk(clk),
    .rst(rst),
    .sck(sck),
    .cs(cs),
    .mosi(mosi),
    .dc(dc),
    .miso(miso),
    .rx(rx_if.slave),
    .rx_overrun(rx_overrun),
    .frame_err(frame_err),
`ifdef SPI_SLAVE_MISO_EN
    .tx_data(tx_data),
    .tx_load(tx_load),
    .tx_ready(tx_ready),
`endif
    .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       dc;
  } exp_t;

  exp_t        sb[$];
  int unsigned last_rise_cyc = 0;
  int unsigned cs_rise_cyc = 0;
  int unsigned fe_count = 0;
  logic        prev_valid = 1'b0;
  logic        prev_fe = 1'b0;
  logic [7:0]  miso_cap = '0;

  always @(negedge clk) begin
    if (rst) begin
      if (rx_if.rx_valid && rx_if.rx_ready) begin
        check("sb_has_word", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("rx_data", 32'(rx_if.rx_data), 32'(e.data));
          check("rx_dc", 32'(rx_if.rx_dc), 32'(e.dc));
          if (!prev_valid) check("rx_latency", cyc - last_rise_cyc, SYNC + 2);
        end
      end
      if (frame_err) begin
        fe_count++;
        check("fe_latency", cyc - cs_rise_cyc, SYNC + 2);
        check("fe_width", 32'(prev_fe), 0);
      end
    end
    prev_valid = rx_if.rx_valid;
    prev_fe    = frame_err;
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_word(input logic [7:0] v, input logic d);
    sb.push_back('{data: v, dc: d});
  endtask

  // early_ready raises rx_ready so the consume lands on the final bit's completion edge
  task automatic send_bits(input logic [7:0] v, input logic d, input int unsigned nbits,
                           input bit early_ready);
    for (int unsigned i = 0; i < nbits; i++) begin
      sck  = 1'b0;
      mosi = v[7-i];
      dc   = d;
      tick(6);
      miso_cap = {miso_cap[6:0], miso};
      sck = 1'b1;
      last_rise_cyc = cyc;
      if (early_ready && i == nbits - 1) begin
        tick(2);
        @(posedge clk);
        #1 rx_if.rx_ready = 1'b1;
        tick(2);
        check("coinc_valid", 32'(rx_if.rx_valid), 1);
        check("coinc_data", 32'(rx_if.rx_data), 32'(v));
        tick(2);
      end else begin
        tick(6);
      end
    end
  endtask

  initial begin
    int unsigned fe0;
    rx_if.rx_ready = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(2);
    check("rst_valid", 32'(rx_if.rx_valid), 0);
    check("rst_data", 32'(rx_if.rx_data), 0);
    check("rst_dc", 32'(rx_if.rx_dc), 0);
    check("rst_overrun", 32'(rx_overrun), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_miso", 32'(miso), 0);
    rst = 1'b1;
    tick(4);

    // single byte, consumer always ready
    rx_if.rx_ready = 1'b1;
    cs = 1'b0;
    tick(6);
    expect_word(8'hA5, 1'b1);
    send_bits(8'hA5, 1'b1, 8, 1'b0);
    cs = 1'b1;
    tick(8);
    check("t1_drained", sb.size(), 0);
    check("t1_valid_low", 32'(rx_if.rx_valid), 0);
`ifndef SPI_SLAVE_MISO_EN
    check("miso_tied", 32'(miso_cap), 0);
`endif

    // overrun: second byte dropped while the first is held
    rx_if.rx_ready = 1'b0;
    cs = 1'b0;
    tick(6);
    expect_word(8'h3C, 1'b0);
    send_bits(8'h3C, 1'b0, 8, 1'b0);
    send_bits(8'hC3, 1'b1, 8, 1'b0);
    cs = 1'b1;
    tick(8);
    check("ovr_valid", 32'(rx_if.rx_valid), 1);
    check("ovr_held_data", 32'(rx_if.rx_data), 32'h3C);
    check("ovr_held_dc", 32'(rx_if.rx_dc), 0);
    check("ovr_set", 32'(rx_overrun), 1);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("ovr_cleared", 32'(rx_overrun), 0);
    check("ovr_still_valid", 32'(rx_if.rx_valid), 1);
    rx_if.rx_ready = 1'b1;
    tick(3);
    check("ovr_drained", sb.size(), 0);
    check("ovr_valid_low", 32'(rx_if.rx_valid), 0);

    // partial word then full byte
    fe0 = fe_count;
    cs = 1'b0;
    tick(6);
    send_bits(8'hF0, 1'b0, 5, 1'b0);
    cs = 1'b1;
    cs_rise_cyc = cyc;
    tick(8);
    check("fe_pulses", fe_count, fe0 + 1);
    check("fe_no_valid", 32'(rx_if.rx_valid), 0);
    cs = 1'b0;
    tick(6);
    expect_word(8'h81, 1'b0);
    send_bits(8'h81, 1'b0, 8, 1'b0);
    cs = 1'b1;
    tick(8);
    check("fe_next_drained", sb.size(), 0);

    // reset in mid-transfer
    fe0 = fe_count;
    cs = 1'b0;
    tick(6);
    send_bits(8'hFF, 1'b1, 3, 1'b0);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rx_if.rx_valid), 0);
    check("mid_rst_data", 32'(rx_if.rx_data), 0);
    check("mid_rst_overrun", 32'(rx_overrun), 0);
    check("mid_rst_frame_err", 32'(frame_err), 0);
    check("mid_rst_miso", 32'(miso), 0);
    cs = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(4);
    cs = 1'b0;
    tick(6);
    expect_word(8'h55, 1'b1);
    send_bits(8'h55, 1'b1, 8, 1'b0);
    cs = 1'b1;
    tick(8);
    check("post_rst_no_fe", fe_count, fe0);
    check("post_rst_drained", sb.size(), 0);

    // completion coincident with consume
    rx_if.rx_ready = 1'b0;
    cs = 1'b0;
    tick(6);
    expect_word(8'h11, 1'b0);
    send_bits(8'h11, 1'b0, 8, 1'b0);
    expect_word(8'h22, 1'b1);
    send_bits(8'h22, 1'b1, 8, 1'b1);
    cs = 1'b1;
    tick(8);
    check("coinc_overrun", 32'(rx_overrun), 0);
    check("coinc_drained", sb.size(), 0);

`ifdef SPI_SLAVE_MISO_EN
    tx_data = 8'h96;
    tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
    check("tx_ready_low", 32'(tx_ready), 0);
    cs = 1'b0;
    tick(6);
    check("tx_ready_back", 32'(tx_ready), 1);
    expect_word(8'h00, 1'b0);
    send_bits(8'h00, 1'b0, 8, 1'b0);
    check("miso_word0", 32'(miso_cap), 32'h96);
    expect_word(8'h00, 1'b0);
    send_bits(8'h00, 1'b0, 8, 1'b0);
    check("miso_word1", 32'(miso_cap), 32'h00);
    cs = 1'b1;
    tick(8);
    check("miso_idle", 32'(miso), 0);
`endif

    for (int i = 0; i < 100 && sb.size() != 0; i++) tick(1);
    check("final_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
